// File: rtl/alu_sequencer_if.sv
// Instruction handshake plus datapath control bundle between the instruction
// source and alu_sequencer.
interface alu_sequencer_if;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [3:0]  a_select;
    logic [3:0]  b_select;
    logic        use_imm;
    logic [15:0] immediate;
    logic [7:0]  opCode;
    logic [15:0] regEnable;
    logic        flag_we;
    logic        busy;

    modport master (
        output instr_valid, instr,
        input  instr_ready, a_select, b_select, use_imm, immediate,
               opCode, regEnable, flag_we, busy
    );

    modport slave (
        input  instr_valid, instr,
        output instr_ready, a_select, b_select, use_imm, immediate,
               opCode, regEnable, flag_we, busy
    );
endinterface

// File: rtl/alu_sequencer.sv
// Instruction FIFO + IDLE/DECODE/EXEC sequencer driving the regfile/ALU/flags datapath.
// Optional retired-instruction counter enabled by defining ALU_SEQ_RETIRE_CNT_EN.
module alu_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    alu_sequencer_if.slave bus
`ifdef ALU_SEQ_RETIRE_CNT_EN
    ,
    output logic [15:0] retired_cnt
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, DECODE, EXEC} state_t;

    state_t        state, nextState;
    logic [15:0]   fifoMem [DEPTH];
    logic [PW-1:0] wrPtr, rdPtr;
    logic [CW-1:0] count;
    logic          push, pop, empty;
    logic [15:0]   ir;

    logic [7:0]    decOp;
    logic [3:0]    decA, decB;
    logic          decUse;
    logic [15:0]   decImm, decRe;

    logic [3:0]    aSel, bSel;
    logic          useImm, flagWe;
    logic [15:0]   imm, regEn;
    logic [7:0]    opReg;

    assign empty           = (count == '0);
    assign bus.instr_ready = (count != FULL_CNT);
    assign push            = bus.instr_valid && bus.instr_ready;

    // FIFO storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) fifoMem[wrPtr] <= bus.instr;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    nextState = DECODE;
                end
            end
            DECODE: nextState = EXEC;
            EXEC: begin
                if (!empty) begin
                    pop       = 1'b1;
                    nextState = DECODE;
                end else begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset)   ir <= '0;
        else if (pop) ir <= fifoMem[rdPtr];
    end

    always_comb begin
        decA   = ir[11:8];
        decB   = ir[3:0];
        decOp  = {4'h0, ir[7:4]};
        decUse = 1'b0;
        decImm = '0;
        if (ir[15:12] != 4'h0) begin
            decOp  = {ir[15:12], 4'h0};
            decB   = '0;
            decUse = 1'b1;
            decImm = {{8{ir[7]}}, ir[7:0]};
        end
        decRe = 16'h0001 << ir[11:8];
        // Compares only update flags.
        if (decOp == 8'h0B || decOp == 8'hB0) decRe = '0;
    end

    // Selects/opcode/immediate hold between instructions; strobes live only in EXEC.
    always_ff @(posedge clk) begin
        if (!reset) begin
            aSel   <= '0;
            bSel   <= '0;
            useImm <= 1'b0;
            imm    <= '0;
            opReg  <= '0;
            regEn  <= '0;
            flagWe <= 1'b0;
        end else if (state == DECODE) begin
            aSel   <= decA;
            bSel   <= decB;
            useImm <= decUse;
            imm    <= decImm;
            opReg  <= decOp;
            regEn  <= decRe;
            flagWe <= 1'b1;
        end else begin
            regEn  <= '0;
            flagWe <= 1'b0;
        end
    end

    assign bus.a_select  = aSel;
    assign bus.b_select  = bSel;
    assign bus.use_imm   = useImm;
    assign bus.immediate = imm;
    assign bus.opCode    = opReg;
    assign bus.regEnable = regEn;
    assign bus.flag_we   = flagWe;
    assign bus.busy      = (state != IDLE) || !empty;

`ifdef ALU_SEQ_RETIRE_CNT_EN
    logic [15:0] retiredCnt;

    always_ff @(posedge clk) begin
        if (!reset)              retiredCnt <= '0;
        else if (state == EXEC)  retiredCnt <= retiredCnt + 16'd1;
    end

    assign retired_cnt = retiredCnt;
`endif
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: single-instruction decode, burst/backpressure,
// reset during EXEC and (when enabled) the retired counter.
module tb_alu_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_sequencer_if ifc();
`ifdef ALU_SEQ_RETIRE_CNT_EN
    logic [15:0] retiredCnt;
`endif

    alu_sequencer #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
`ifdef ALU_SEQ_RETIRE_CNT_EN
        ,
        .retired_cnt (retiredCnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Push one instruction into an idle block and check each cycle of its life.
    task automatic runOne(input logic [15:0] w, input logic [7:0] expOp, input logic [3:0] expA,
                          input logic [3:0] expB, input logic expUse, input logic [15:0] expImm,
                          input logic [15:0] expRe);
        @(negedge clk);
        ifc.instr_valid = 1'b1;
        ifc.instr       = w;
        @(posedge clk);
        @(negedge clk);
        ifc.instr_valid = 1'b0;
        chk("busy_after_push", ifc.busy, 1);
        @(posedge clk);
        @(negedge clk);
        chk("decode_re", ifc.regEnable, 0);
        @(posedge clk);
        @(negedge clk);
        chk("exec_op", ifc.opCode, expOp);
        chk("exec_a", ifc.a_select, expA);
        chk("exec_b", ifc.b_select, expB);
        chk("exec_use", ifc.use_imm, expUse);
        chk("exec_imm", ifc.immediate, expImm);
        chk("exec_re", ifc.regEnable, expRe);
        chk("exec_fwe", ifc.flag_we, 1);
        @(posedge clk);
        @(negedge clk);
        chk("post_re", ifc.regEnable, 0);
        chk("post_fwe", ifc.flag_we, 0);
        chk("post_busy", ifc.busy, 0);
        chk("post_op_hold", ifc.opCode, expOp);
    endtask

    initial begin
        int          recA[$];
        logic [15:0] recRe[$];
        int          recCyc[$];
        logic        sawFull;
        int          pushed;
        int          execs;

        ifc.instr_valid = 1'b0;
        ifc.instr       = '0;
        reset           = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        chk("rst_ready", ifc.instr_ready, 1);
        chk("rst_busy", ifc.busy, 0);
        chk("rst_re", ifc.regEnable, 0);
        chk("rst_fwe", ifc.flag_we, 0);
        chk("rst_op", ifc.opCode, 0);
        chk("rst_imm", ifc.immediate, 0);

        runOne(16'h0355, 8'h05, 4'd3, 4'd5, 1'b0, 16'h0000, 16'h0008);
        runOne(16'h52FD, 8'h50, 4'd2, 4'd0, 1'b1, 16'hFFFD, 16'h0004);
        runOne(16'h01B2, 8'h0B, 4'd1, 4'd2, 1'b0, 16'h0000, 16'h0000);

        // Burst of 8 with valid held high: instr k is ADD rk,r1.
        sawFull = 1'b0;
        pushed  = 0;
        fork
            begin
                int budget = 0;
                logic rdy;
                while (pushed < 8 && budget < 100) begin
                    @(negedge clk);
                    ifc.instr_valid = 1'b1;
                    ifc.instr       = {4'h0, 4'(pushed), 8'h51};
                    rdy = ifc.instr_ready;
                    if (!rdy) sawFull = 1'b1;
                    @(posedge clk);
                    if (rdy) pushed++;
                    budget++;
                end
                @(negedge clk);
                ifc.instr_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    @(negedge clk);
                    if (ifc.flag_we) begin
                        recA.push_back(int'(ifc.a_select));
                        recRe.push_back(ifc.regEnable);
                        recCyc.push_back(c);
                    end
                end
            end
        join
        chk("burst_pushed", pushed, 8);
        chk("burst_full_seen", sawFull, 1);
        chk("burst_count", recA.size(), 8);
        for (int i = 0; i < recA.size() && i < 8; i++) begin
            chk($sformatf("burst_a%0d", i), recA[i], i);
            chk($sformatf("burst_re%0d", i), recRe[i], 32'h1 << i);
            if (i > 0) chk($sformatf("burst_gap%0d", i), recCyc[i] - recCyc[i-1], 2);
        end
        chk("burst_ready_end", ifc.instr_ready, 1);
        chk("burst_busy_end", ifc.busy, 0);

        // Reset during EXEC of the first of three, with two still queued.
        @(negedge clk);
        ifc.instr_valid = 1'b1;
        ifc.instr       = 16'h0A12;
        @(posedge clk);
        @(negedge clk);
        ifc.instr = 16'h0B12;
        @(posedge clk);
        @(negedge clk);
        ifc.instr = 16'h0C12;
        @(posedge clk);
        @(negedge clk);
        ifc.instr_valid = 1'b0;
        chk("midrst_exec_re", ifc.regEnable, 16'h0400);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_re", ifc.regEnable, 0);
        chk("midrst_busy", ifc.busy, 0);
        chk("midrst_ready", ifc.instr_ready, 1);
        reset = 1'b1;
        execs = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ifc.flag_we || ifc.regEnable != 0) execs++;
        end
        chk("midrst_no_exec", execs, 0);

`ifdef ALU_SEQ_RETIRE_CNT_EN
        chk("ret_reset", retiredCnt, 0);
        runOne(16'h0355, 8'h05, 4'd3, 4'd5, 1'b0, 16'h0000, 16'h0008);
        runOne(16'h52FD, 8'h50, 4'd2, 4'd0, 1'b1, 16'hFFFD, 16'h0004);
        runOne(16'h01B2, 8'h0B, 4'd1, 4'd2, 1'b0, 16'h0000, 16'h0000);
        chk("ret_three", retiredCnt, 3);
        @(negedge clk);
        force dut.retiredCnt = 16'hFFFF;
        #1;
        release dut.retiredCnt;
        chk("ret_forced", retiredCnt, 16'hFFFF);
        runOne(16'h0355, 8'h05, 4'd3, 4'd5, 1'b0, 16'h0000, 16'h0008);
        chk("ret_wrap", retiredCnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Instruction-driven controller for the 16-entry register file / ALU / flags datapath. Accepts 16-bit instruction words through a valid/ready handshake into a small FIFO, decodes each one, and drives the datapath control inputs `a_select`, `b_select`, `use_imm`, `immediate`, `opCode` and `regEnable` for exactly one execute cycle per instruction. It also strobes `flag_we` so the integrating top can gate the flags register. It sits between the instruction source (test harness now, fetch unit later) and the datapath.

## Interface
- `DEPTH`, 4: instruction FIFO depth, power of two, ≥2.
- `clk`  in  1  single clock; everything updates on its rising edge.
- `reset`  in  1  synchronous, active-low; low at a rising edge resets the block.
- `instr_valid`  in  1  `instr` is valid this cycle.
- `instr`  in  16  instruction word.
- `instr_ready`  out  1  `!full`; a push occurs on an edge where `instr_valid && instr_ready`.
- `a_select`  out  4  A-mux select; drives Rdest.
- `b_select`  out  4  B-mux select; drives Rsrc.
- `use_imm`  out  1  selects the immediate into ALU input B.
- `immediate`  out  16  sign-extended imm8.
- `opCode`  out  8  ALU opcode.
- `regEnable`  out  16  one-hot write enable; all zero outside EXEC.
- `flag_we`  out  1  high during EXEC only.
- `busy`  out  1  `(state != IDLE) || !empty`.
- `retired_cnt`  out  16  present only with `ALU_SEQ_RETIRE_CNT_EN`.

## Operation
- Instruction decode:
  - Register type when `instr[15:12] == 0`:
    - `opCode = {4'h0, instr[7:4]}`, `a_select = instr[11:8]`, `b_select = instr[3:0]`, `use_imm = 0`, `immediate = 0`.
  - Immediate type otherwise:
    - `opCode = {instr[15:12], 4'h0}`, `a_select = instr[11:8]`, `b_select = 0`, `use_imm = 1`, `immediate = {{8{instr[7]}}, instr[7:0]}`.
- Writeback:
  - `regEnable = 1 << instr[11:8]`.
  - Compare (`opCode` 8'h0B or 8'hB0) gives `regEnable = 0`; `flag_we` is still 1.
- FIFO:
  - Circular buffer, DEPTH entries, pointers wrap modulo DEPTH.
  - Occupancy counter is 0..DEPTH.
  - Push and pop on the same edge leave the count unchanged.
  - A push is impossible when full because `instr_ready` is low. A pop is impossible when empty.
- FSM, states IDLE, DECODE, EXEC:
  - IDLE: if not empty, pop the head into IR and go to DECODE; otherwise stay in IDLE.
  - DECODE: register the decoded fields into the output registers; go to EXEC.
  - EXEC: outputs are valid and `regEnable` / `flag_we` are asserted for this one cycle.
    - If not empty: pop into IR and go to DECODE.
    - Otherwise: go to IDLE.
  - On leaving EXEC, `regEnable` and `flag_we` are cleared.
  - Select, opcode and immediate outputs hold their last values until the next DECODE. This keeps the mux outputs stable.
- Ordering: instructions execute strictly in push order; none is dropped or duplicated.
- RAW hazards: none. The datapath reads registers combinationally in EXEC, and the previous write has already completed at the end of the prior EXEC.

## Timing
- Reset (reset low at an edge):
  - State IDLE; FIFO flushed (count 0, pointers 0).
  - IR = 0; all outputs 0; `retired_cnt` = 0.
  - `instr_ready` = 1 after the reset edge.
  - A push presented on a reset edge is discarded.
- Reset mid-operation: an in-flight DECODE or EXEC is abandoned. `regEnable` is 0 from the cycle after the reset edge and no register write occurs at any later edge.
- Latency, instruction accepted at edge E0 into an empty, idle block:
  - Popped at E1; outputs valid and `regEnable` high during cycle E2→E3.
  - Register and flags are written at E3.
- Throughput: one instruction per 2 cycles when back-to-back (EXEC→DECODE→EXEC).
- `instr_ready` is derived from the registered count and changes only at edges.
- `busy` falls in the cycle after the final EXEC when the FIFO is empty.

## Configuration
- `ALU_SEQ_RETIRE_CNT_EN` defined:
  - Adds the `retired_cnt` port, a 16-bit counter of EXEC cycles.
  - Increments at each edge that ends an EXEC cycle, including compares.
  - Wraps from 16'hFFFF to 0; cleared by reset.
- Not defined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Reset, then push 16'h0355 (ADD r3,r5) at E0 → in cycle E2: `opCode` 8'h05, `a_select` 3, `b_select` 5, `use_imm` 0, `regEnable` 16'h0008, `flag_we` 1, each for exactly one cycle; `busy` 0 afterwards.
- Push 16'h52FD (ADDI r2,#-3) → `opCode` 8'h50, `use_imm` 1, `immediate` 16'hFFFD, `regEnable` 16'h0004.
- Push 16'h01B2 (CMP r1,r2) → `opCode` 8'h0B, `flag_we` 1, `regEnable` 16'h0000.
- Push 8 instructions with `instr_valid` held high every cycle and DEPTH=4:
  - `instr_ready` drops once count reaches 4 and recovers as the FIFO drains.
  - All 8 execute in order with `regEnable` pulses exactly 2 cycles apart; no loss or duplication.
- Drive reset low during an EXEC cycle with 2 instructions queued → next cycle `regEnable` 0, `busy` 0, `instr_ready` 1; the queued instructions never execute.
- With `ALU_SEQ_RETIRE_CNT_EN`:
  - Execute 3 instructions → `retired_cnt` 3.
  - Force a count of 16'hFFFF, execute 1 → `retired_cnt` 0.
